// File: rtl/psum_pkg.sv
// Shared constants, state encoding and helpers for the partial-sum dequant loader.
package psum_pkg;

  localparam int unsigned ARRAY_SIZE_DEF        = 256;
  localparam int unsigned SRAM_DATA_WIDTH_DEF   = 32;
  localparam int unsigned DATA_WIDTH_DEF        = 8;
  localparam int unsigned OUTPUT_DATA_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF        = 10;

  localparam int unsigned ORI_WIDTH = 2 * DATA_WIDTH_DEF + 5;
  localparam int unsigned EPW       = SRAM_DATA_WIDTH_DEF / OUTPUT_DATA_WIDTH_DEF;
  localparam int unsigned W         = ARRAY_SIZE_DEF / EPW;

  // Codes the quantizer emits when it clips.
  localparam logic signed [15:0] SAT_POS = 16'sh7FFF;
  localparam logic signed [15:0] SAT_NEG = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic int unsigned ori_width_f(input int unsigned data_width);
    return 2 * data_width + 5;
  endfunction

endpackage

// File: rtl/psum_dequant_loader_if.sv
// SRAM read port, row handoff and control bus of the loader.
// PSUM_SAT_CNT_EN adds the sat_cnt signal.
interface psum_dequant_loader_if
  import psum_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE      = ARRAY_SIZE_DEF,
  parameter int unsigned SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF
);
  localparam int unsigned ORI_W = ori_width_f(DATA_WIDTH);

  logic                          start;
  logic [ADDR_WIDTH-1:0]         base_addr;
  logic                          busy;
  logic                          sram_ren;
  logic [ADDR_WIDTH-1:0]         sram_raddr;
  logic [SRAM_DATA_WIDTH-1:0]    sram_rdata;
  logic                          row_valid;
  logic                          row_ready;
  logic [ARRAY_SIZE*ORI_W-1:0]   row_data;
`ifdef PSUM_SAT_CNT_EN
  logic [$clog2(ARRAY_SIZE+1)-1:0] sat_cnt;
`endif

  modport master (
    input  start, base_addr, sram_rdata, row_ready,
`ifdef PSUM_SAT_CNT_EN
    output sat_cnt,
`endif
    output busy, sram_ren, sram_raddr, row_valid, row_data
  );

  modport slave (
    output start, base_addr, sram_rdata, row_ready,
`ifdef PSUM_SAT_CNT_EN
    input  sat_cnt,
`endif
    input  busy, sram_ren, sram_raddr, row_valid, row_data
  );

endinterface

// File: rtl/psum_word_widen.sv
// Splits one SRAM word into quantized elements and sign-extends each to accumulator width.
// PSUM_SAT_CNT_EN adds a count of clipped codes in the word.
module psum_word_widen
  import psum_pkg::*;
#(
  parameter int unsigned SRAM_DATA_WIDTH   = SRAM_DATA_WIDTH_DEF,
  parameter int unsigned OUTPUT_DATA_WIDTH = OUTPUT_DATA_WIDTH_DEF,
  parameter int unsigned ORI_WIDTH         = psum_pkg::ORI_WIDTH,
  localparam int unsigned N_EPW            = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH,
  localparam int unsigned WSAT_W           = $clog2(N_EPW + 1)
) (
  input  logic [SRAM_DATA_WIDTH-1:0]   word_i,
`ifdef PSUM_SAT_CNT_EN
  output logic [WSAT_W-1:0]            sat_o,
`endif
  output logic [N_EPW*ORI_WIDTH-1:0]   elems_o
);

  // Sign-extension with no shift is the exact inverse of the quantizer's in-range path.
  always_comb begin
    elems_o = '0;
`ifdef PSUM_SAT_CNT_EN
    sat_o = '0;
`endif
    for (int j = 0; j < N_EPW; j++) begin
      elems_o[j*ORI_WIDTH +: ORI_WIDTH] =
        ORI_WIDTH'($signed(word_i[j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]));
`ifdef PSUM_SAT_CNT_EN
      if (($signed(word_i[j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]) == SAT_POS) ||
          ($signed(word_i[j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]) == SAT_NEG)) begin
        sat_o = sat_o + WSAT_W'(1);
      end else begin
        sat_o = sat_o;
      end
`endif
    end
  end

endmodule

// File: rtl/psum_dequant_loader.sv
// Fetches one row of quantized partial sums from SRAM, widens it and hands it to the array.
// PSUM_SAT_CNT_EN adds sat_cnt: number of clipped codes in the held row.
module psum_dequant_loader
  import psum_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE        = ARRAY_SIZE_DEF,
  parameter int unsigned SRAM_DATA_WIDTH   = SRAM_DATA_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int unsigned OUTPUT_DATA_WIDTH = OUTPUT_DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 srst,
  psum_dequant_loader_if.master bus
);

  localparam int unsigned ORI_W     = ori_width_f(DATA_WIDTH);
  localparam int unsigned N_EPW     = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH;
  localparam int unsigned N_W       = ARRAY_SIZE / N_EPW;
  localparam int unsigned WORD_BITS = N_EPW * ORI_W;
  localparam int unsigned ROW_BITS  = ARRAY_SIZE * ORI_W;
  localparam int unsigned CNT_W     = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(N_W - 1);
`ifdef PSUM_SAT_CNT_EN
  localparam int unsigned SAT_W  = $clog2(ARRAY_SIZE + 1);
  localparam int unsigned WSAT_W = $clog2(N_EPW + 1);
`endif

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic                    ren_q, ren_d;
  logic                    cap_q, cap_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic [ROW_BITS-1:0]     row_q, row_d;
  logic [WORD_BITS-1:0]    word_elems;
  logic                    accept;
`ifdef PSUM_SAT_CNT_EN
  logic [SAT_W-1:0]        sat_q, sat_d;
  logic [WSAT_W-1:0]       word_sat;
`endif

  psum_word_widen #(
    .SRAM_DATA_WIDTH  (SRAM_DATA_WIDTH),
    .OUTPUT_DATA_WIDTH(OUTPUT_DATA_WIDTH),
    .ORI_WIDTH        (ORI_W)
  ) u_widen (
    .word_i (bus.sram_rdata),
`ifdef PSUM_SAT_CNT_EN
    .sat_o  (word_sat),
`endif
    .elems_o(word_elems)
  );

  assign accept = (state_q == ST_IDLE) && bus.start;

  // State register.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start is only honoured in IDLE, so a start during the handshake is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH; else state_d = ST_IDLE;
      ST_FETCH: if (rd_cnt_q == LAST_RD) state_d = ST_DRAIN; else state_d = ST_FETCH;
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD:  if (valid_q && bus.row_ready) state_d = ST_IDLE; else state_d = ST_HOLD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read issue, capture and output values, all computed for the next cycle.
  always_comb begin
    base_d   = base_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    raddr_d  = raddr_q;
    row_d    = row_q;
    ren_d    = 1'b0;
    cap_d    = ren_q;
`ifdef PSUM_SAT_CNT_EN
    sat_d    = sat_q;
`endif
    if (accept) begin
      base_d   = bus.base_addr;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      ren_d    = 1'b1;
      raddr_d  = bus.base_addr;
`ifdef PSUM_SAT_CNT_EN
      sat_d    = '0;
`endif
    end else if ((state_q == ST_FETCH) && (rd_cnt_q != LAST_RD)) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
      ren_d    = 1'b1;
      raddr_d  = base_q + ADDR_WIDTH'(rd_cnt_q) + ADDR_WIDTH'(1);
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    // Data of the read issued last cycle is on sram_rdata now.
    if (cap_q) begin
      row_d[wr_cnt_q*WORD_BITS +: WORD_BITS] = word_elems;
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
`ifdef PSUM_SAT_CNT_EN
      sat_d    = sat_q + SAT_W'(word_sat);
`endif
    end else begin
      wr_cnt_d = wr_cnt_d;
    end
    valid_d = (state_d == ST_HOLD);
    busy_d  = (state_d != ST_IDLE);
  end

  // Datapath and output registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (srst) begin
      base_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      raddr_q  <= '0;
      ren_q    <= 1'b0;
      cap_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      row_q    <= '0;
`ifdef PSUM_SAT_CNT_EN
      sat_q    <= '0;
`endif
    end else begin
      base_q   <= base_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      raddr_q  <= raddr_d;
      ren_q    <= ren_d;
      cap_q    <= cap_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      row_q    <= row_d;
`ifdef PSUM_SAT_CNT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  assign bus.sram_ren   = ren_q;
  assign bus.sram_raddr = raddr_q;
  assign bus.row_valid  = valid_q;
  assign bus.row_data   = row_q;
  assign bus.busy       = busy_q;
`ifdef PSUM_SAT_CNT_EN
  assign bus.sat_cnt    = sat_q;
`endif

endmodule

// File: tb/tb_psum_dequant_loader.sv
// Directed bench for psum_dequant_loader with a 4-element row (two SRAM words per row).
module tb_psum_dequant_loader;

  localparam int unsigned AS  = 4;
  localparam int unsigned SDW = 32;
  localparam int unsigned DW  = 8;
  localparam int unsigned ODW = 16;
  localparam int unsigned AW  = 10;

  logic clk;
  logic srst;
  logic [SDW-1:0] mem [0:1023];
  int   rd_count;
  int   n_cmp;
  int   n_fail;

  psum_dequant_loader_if #(.ARRAY_SIZE(AS), .SRAM_DATA_WIDTH(SDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  psum_dequant_loader #(
    .ARRAY_SIZE(AS), .SRAM_DATA_WIDTH(SDW), .DATA_WIDTH(DW),
    .OUTPUT_DATA_WIDTH(ODW), .ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .srst(srst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency SRAM model plus read counter.
  always @(posedge clk) begin
    if (bus.sram_ren) begin
      bus.sram_rdata <= mem[bus.sram_raddr];
      rd_count <= rd_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (start was sampled in cycle 0).
  task automatic start_row(input logic [AW-1:0] base);
    bus.start = 1'b1;
    bus.base_addr = base;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    step(); step();
    n_cmp++; if (bus.sram_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %0h want 0", bus.sram_ren); end
    n_cmp++; if (bus.sram_raddr !== 10'h000) begin n_fail++; $display("FAIL reset_raddr: got %0h want 0", bus.sram_raddr); end
    n_cmp++; if (bus.row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", bus.row_valid); end
    n_cmp++; if (bus.row_data !== 84'h0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", bus.row_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", bus.busy); end
`ifdef PSUM_SAT_CNT_EN
    n_cmp++; if (bus.sat_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_sat: got %0d want 0", bus.sat_cnt); end
`endif
    srst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [83:0] exp_row;
    exp_row = {21'h1F8000, 21'h007FFF, 21'h1FFFFF, 21'h000001};
    start_row(10'h010);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_c1: got %0h want 1", bus.busy); end
    n_cmp++; if (bus.sram_ren !== 1'b1 || bus.sram_raddr !== 10'h010) begin n_fail++; $display("FAIL basic_rd_c1: got ren %0h addr %0h want 1 010", bus.sram_ren, bus.sram_raddr); end
    step();
    n_cmp++; if (bus.sram_ren !== 1'b1 || bus.sram_raddr !== 10'h011) begin n_fail++; $display("FAIL basic_rd_c2: got ren %0h addr %0h want 1 011", bus.sram_ren, bus.sram_raddr); end
    step();
    n_cmp++; if (bus.sram_ren !== 1'b0 || bus.row_valid !== 1'b0) begin n_fail++; $display("FAIL basic_c3: got ren %0h valid %0h want 0 0", bus.sram_ren, bus.row_valid); end
    step();
    n_cmp++; if (bus.row_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_c4: got %0h want 1", bus.row_valid); end
    n_cmp++; if (bus.row_data !== exp_row) begin n_fail++; $display("FAIL basic_data: got %0h want %0h", bus.row_data, exp_row); end
`ifdef PSUM_SAT_CNT_EN
    n_cmp++; if (bus.sat_cnt !== 3'd2) begin n_fail++; $display("FAIL basic_sat: got %0d want 2", bus.sat_cnt); end
`endif
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
    n_cmp++; if (bus.row_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got valid %0h busy %0h want 0 0", bus.row_valid, bus.busy); end
  endtask

`ifdef PSUM_SAT_CNT_EN
  task automatic test_sat_clear();
    start_row(10'h040);
    n_cmp++; if (bus.sat_cnt !== 3'd0) begin n_fail++; $display("FAIL sat_clear_c1: got %0d want 0", bus.sat_cnt); end
    step(); step(); step();
    n_cmp++; if (bus.row_valid !== 1'b1 || bus.sat_cnt !== 3'd0) begin n_fail++; $display("FAIL sat_zero_row: got valid %0h sat %0d want 1 0", bus.row_valid, bus.sat_cnt); end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
  endtask
`endif

  task automatic test_backpressure();
    logic [83:0] exp_row;
    exp_row = {21'h1F8000, 21'h007FFF, 21'h1FFFFF, 21'h000001};
    start_row(10'h010);
    step(); step(); step();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (bus.row_valid !== 1'b1 || bus.sram_ren !== 1'b0 || bus.row_data !== exp_row) begin
        n_fail++; $display("FAIL bp_hold_%0d: got valid %0h ren %0h data %0h want 1 0 %0h", i, bus.row_valid, bus.sram_ren, bus.row_data, exp_row);
      end
      step();
    end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
    n_cmp++; if (bus.row_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: got valid %0h busy %0h want 0 0", bus.row_valid, bus.busy); end
    n_cmp++; if (bus.row_data !== exp_row) begin n_fail++; $display("FAIL bp_data_kept: got %0h want %0h", bus.row_data, exp_row); end
  endtask

  task automatic test_illegal_start();
    int rc0;
    logic [83:0] exp_row;
    exp_row = {21'h1FFFFE, 21'h007FFE, 21'h000002, 21'h000003};
    rc0 = rd_count;
    start_row(10'h010);
    bus.start = 1'b1;
    bus.base_addr = 10'h030;
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.sram_raddr !== 10'h011) begin n_fail++; $display("FAIL ill_fetch_addr: got %0h want 011", bus.sram_raddr); end
    step(); step();
    bus.row_ready = 1'b1;
    bus.start = 1'b1;
    bus.base_addr = 10'h030;
    step();
    bus.row_ready = 1'b0;
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.sram_ren !== 1'b0) begin n_fail++; $display("FAIL ill_hs_start: got busy %0h ren %0h want 0 0", bus.busy, bus.sram_ren); end
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.sram_ren !== 1'b0) begin n_fail++; $display("FAIL ill_idle: got busy %0h ren %0h want 0 0", bus.busy, bus.sram_ren); end
    n_cmp++; if (rd_count - rc0 !== 2) begin n_fail++; $display("FAIL ill_read_count: got %0d want 2", rd_count - rc0); end
    start_row(10'h020);
    n_cmp++; if (bus.sram_ren !== 1'b1 || bus.sram_raddr !== 10'h020) begin n_fail++; $display("FAIL ill_new_rd: got ren %0h addr %0h want 1 020", bus.sram_ren, bus.sram_raddr); end
    step(); step(); step();
    n_cmp++; if (bus.row_valid !== 1'b1 || bus.row_data !== exp_row) begin n_fail++; $display("FAIL ill_new_row: got valid %0h data %0h want 1 %0h", bus.row_valid, bus.row_data, exp_row); end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [83:0] exp_row;
    exp_row = {21'h1FFFFE, 21'h007FFE, 21'h000002, 21'h000003};
    start_row(10'h010);
    srst = 1'b1;
    step();
    n_cmp++; if (bus.sram_ren !== 1'b0 || bus.sram_raddr !== 10'h000 || bus.busy !== 1'b0 || bus.row_valid !== 1'b0 || bus.row_data !== 84'h0) begin
      n_fail++; $display("FAIL rst_mid_outs: got ren %0h addr %0h busy %0h valid %0h data %0h want all 0", bus.sram_ren, bus.sram_raddr, bus.busy, bus.row_valid, bus.row_data);
    end
    srst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (bus.row_valid !== 1'b0 || bus.sram_ren !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet_%0d: got valid %0h ren %0h want 0 0", i, bus.row_valid, bus.sram_ren); end
    end
    start_row(10'h020);
    step(); step(); step();
    n_cmp++; if (bus.row_valid !== 1'b1 || bus.row_data !== exp_row) begin n_fail++; $display("FAIL rst_mid_fresh: got valid %0h data %0h want 1 %0h", bus.row_valid, bus.row_data, exp_row); end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [83:0] exp_row;
    exp_row = {21'h1F8001, 21'h000006, 21'h000005, 21'h000004};
    start_row(10'h3FF);
    n_cmp++; if (bus.sram_ren !== 1'b1 || bus.sram_raddr !== 10'h3FF) begin n_fail++; $display("FAIL wrap_rd0: got ren %0h addr %0h want 1 3ff", bus.sram_ren, bus.sram_raddr); end
    step();
    n_cmp++; if (bus.sram_ren !== 1'b1 || bus.sram_raddr !== 10'h000) begin n_fail++; $display("FAIL wrap_rd1: got ren %0h addr %0h want 1 000", bus.sram_ren, bus.sram_raddr); end
    step(); step();
    n_cmp++; if (bus.row_valid !== 1'b1 || bus.row_data !== exp_row) begin n_fail++; $display("FAIL wrap_row: got valid %0h data %0h want 1 %0h", bus.row_valid, bus.row_data, exp_row); end
    bus.row_ready = 1'b1;
    step();
    bus.row_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rd_count = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    mem[10'h010] = 32'hFFFF_0001;
    mem[10'h011] = 32'h8000_7FFF;
    mem[10'h020] = 32'h0002_0003;
    mem[10'h021] = 32'hFFFE_7FFE;
    mem[10'h030] = 32'hDEAD_BEEF;
    mem[10'h031] = 32'hDEAD_BEEF;
    mem[10'h3FF] = 32'h0005_0004;
    mem[10'h000] = 32'h8001_0006;
    bus.sram_rdata = 32'h0;
    bus.start = 1'b0;
    bus.base_addr = 10'h000;
    bus.row_ready = 1'b0;
    srst = 1'b1;
    test_reset();
    test_basic();
`ifdef PSUM_SAT_CNT_EN
    test_sat_clear();
`endif
    test_backpressure();
    test_illegal_start();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
